// File: rtl/sigmoid_alu_pkg.sv
// Shared widths, types and saturation helper for the sigmoid ALU datapath.
`timescale 1ns/1ps
package sigmoid_alu_pkg;

   localparam int unsigned IN_W  = 8;
   localparam int unsigned OUT_W = IN_W + 2;
   localparam int unsigned SAT_W = 8;

   typedef logic signed [IN_W-1:0]  operand_t;
   typedef logic signed [OUT_W-1:0] sum_t;

   localparam sum_t SAT_MAX = 10'sd127;
   localparam sum_t SAT_MIN = -10'sd128;

   typedef struct packed {
      logic [SAT_W-1:0] val;
      logic             flag;
   } sat_t;

   // Clamp a full-precision sum into the signed SAT_W range.
   function automatic sat_t saturate(sum_t s);
      sat_t r;
      r.flag = 1'b1;
      if (s > SAT_MAX) begin
         r.val = SAT_MAX[SAT_W-1:0];
      end else if (s < SAT_MIN) begin
         r.val = SAT_MIN[SAT_W-1:0];
      end else begin
         r.val  = s[SAT_W-1:0];
         r.flag = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/sigmoid_alu_add2.sv
// Signed two-operand adder; result is SumW bits wide with both operands sign-extended.
`timescale 1ns/1ps
module sigmoid_alu_add2 #(
   parameter int unsigned InW  = 8,
   parameter int unsigned SumW = InW + 1
) (
   input  logic [InW-1:0]  a,
   input  logic [InW-1:0]  b,
   output logic [SumW-1:0] sum
);

   logic signed [SumW-1:0] a_ext;
   logic signed [SumW-1:0] b_ext;

   assign a_ext = $signed({{(SumW - InW){a[InW-1]}}, a});
   assign b_ext = $signed({{(SumW - InW){b[InW-1]}}, b});
   assign sum   = a_ext + b_ext;

endmodule

// File: rtl/sigmoid_alu_4_way_adder.sv
// Four-operand signed adder: combinational exact sum plus a registered,
// valid-qualified copy with an 8-bit saturated view for the lookup stage.
`timescale 1ns/1ps
module sigmoid_alu_4_way_adder
   import sigmoid_alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   in1,
   input  logic [IN_W-1:0]   in2,
   input  logic [IN_W-1:0]   in3,
   input  logic [IN_W-1:0]   in4,
   input  logic              in_valid,
   output logic [OUT_W-1:0]  out,
   output logic [OUT_W-1:0]  out_q,
   output logic              out_valid,
   output logic [SAT_W-1:0]  sat_q,
   output logic              sat_flag
);

   logic [IN_W:0]   sum_lo;
   logic [IN_W:0]   sum_hi;
   sat_t            sat;

   sigmoid_alu_add2 #(
      .InW  (IN_W),
      .SumW (IN_W + 1)
   ) u_add_lo (
      .a   (in1),
      .b   (in2),
      .sum (sum_lo)
   );

   sigmoid_alu_add2 #(
      .InW  (IN_W),
      .SumW (IN_W + 1)
   ) u_add_hi (
      .a   (in3),
      .b   (in4),
      .sum (sum_hi)
   );

   sigmoid_alu_add2 #(
      .InW  (IN_W + 1),
      .SumW (OUT_W)
   ) u_add_fin (
      .a   (sum_lo),
      .b   (sum_hi),
      .sum (out)
   );

   // out_q holds its last capture while in_valid is low; only the flag drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_q <= out;
         end
      end
   end

   always_comb begin
      sat      = saturate(sum_t'(out_q));
      sat_q    = sat.val;
      sat_flag = sat.flag;
   end

endmodule

// File: tb/tb_sigmoid_alu_4_way_adder.sv
// Self-checking bench for sigmoid_alu_4_way_adder: directed corners, a clockless
// sweep of the combinational sum, async reset, hold behaviour and random traffic.
`timescale 1ns/1ps
module tb_sigmoid_alu_4_way_adder;

   logic       clk;
   logic       clk_en;
   logic       rst;
   logic [7:0] in1, in2, in3, in4;
   logic       in_valid;
   logic [9:0] out;
   logic [9:0] out_q;
   logic       out_valid;
   logic [7:0] sat_q;
   logic       sat_flag;

   int total;
   int bad;

   // Reference state: the last captured sum as a plain integer.
   int exp_q;
   int exp_valid;

   sigmoid_alu_4_way_adder dut (
      .clk       (clk),
      .rst       (rst),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in4       (in4),
      .in_valid  (in_valid),
      .out       (out),
      .out_q     (out_q),
      .out_valid (out_valid),
      .sat_q     (sat_q),
      .sat_flag  (sat_flag)
   );

   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   function automatic int sb(logic [7:0] v);
      return (v > 8'd127) ? int'(v) - 256 : int'(v);
   endfunction

   function automatic int ref_sum();
      return sb(in1) + sb(in2) + sb(in3) + sb(in4);
   endfunction

   function automatic int ref_sat(int s);
      if (s > 127)  return 127;
      if (s < -128) return -128;
      return s;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_comb(input string tag);
      int s;
      logic [9:0] e;
      s = ref_sum();
      e = s[9:0];
      check(tag, int'(out), int'(e));
   endtask

   task automatic check_reg(input string tag);
      logic [9:0] eq;
      logic [7:0] es;
      int sat;
      eq  = exp_q[9:0];
      sat = ref_sat(exp_q);
      es  = sat[7:0];
      check({tag, ".out_q"}, int'(out_q), int'(eq));
      check({tag, ".out_valid"}, int'(out_valid), exp_valid);
      check({tag, ".sat_q"}, int'(sat_q), int'(es));
      check({tag, ".sat_flag"}, int'(sat_flag), (sat != exp_q) ? 1 : 0);
   endtask

   // Advance one clock and settle; the reference captures as the DUT should.
   task automatic tick();
      int s;
      s = ref_sum();
      @(posedge clk);
      if (!rst) begin
         exp_valid = in_valid ? 1 : 0;
         if (in_valid) exp_q = s;
      end
      #1;
   endtask

   task automatic drive(input logic [7:0] a, b, c, d, input logic v);
      in1 = a; in2 = b; in3 = c; in4 = d; in_valid = v;
      #1;
   endtask

   initial begin
      logic [31:0] vec;
      total     = 0;
      bad       = 0;
      exp_q     = 0;
      exp_valid = 0;
      clk_en    = 1'b1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      {in4, in3, in2, in1} = 32'h0403_0201;
      #1;
      check_comb("reset.out_tracks");
      repeat (2) @(posedge clk);
      #1;
      check_reg("reset");
      rst = 1'b0;

      // Directed corners
      drive(8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
      check("max.out", int'(out), 10'h1FC);
      tick();
      check_reg("max");
      check("max.sat_q_lit", int'(sat_q), 8'h7F);

      drive(8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
      check("min.out", int'(out), 10'h200);
      tick();
      check_reg("min");
      check("min.sat_q_lit", int'(sat_q), 8'h80);

      drive(8'h7F, 8'h80, 8'h01, 8'hFF, 1'b1);
      check("mixed.out", int'(out), 10'h3FF);
      tick();
      check_reg("mixed");
      check("mixed.sat_flag_lit", int'(sat_flag), 0);

      // Hold: in_valid low, inputs keep changing
      for (int i = 0; i < 3; i++) begin
         drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
         check_comb("hold.out");
         tick();
         check_reg("hold");
      end

      // Async reset mid-cycle after a capture
      drive(8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
      tick();
      check_reg("cap160");
      #2;
      rst = 1'b1;
      #0.5;
      exp_q     = 0;
      exp_valid = 0;
      check_reg("async_rst");
      check("async_rst.out", int'(out), 160);
      @(posedge clk);
      #1;
      check_reg("rst_held");
      #2;
      rst = 1'b0;
      in_valid = 1'b1;
      tick();
      check_reg("first_after_rst");

      // Randomised traffic with occasional mid-cycle resets
      for (int i = 0; i < 300; i++) begin
         drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 2) != 0));
         check_comb("rand.out");
         if ($urandom_range(0, 30) == 0) begin
            rst = 1'b1;
            #1;
            exp_q     = 0;
            exp_valid = 0;
            check_reg("rand_rst");
            rst = 1'b0;
         end
         tick();
         check_reg("rand");
      end

      // Clockless sweep of the packed operand vector
      clk_en = 1'b0;
      #20;
      for (longint v = 0; v < 64'h1_0000_0000; v += 19743) begin
         vec = v[31:0];
         {in4, in3, in2, in1} = vec;
         #0.9;
         check_comb("sweep.out");
         #0.1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
